// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access type decode, FSM state encoding
// and funct3 constants.
package lsu_pkg;

   typedef enum logic [7:0] {
      LS_B    = 8'h01,
      LS_H    = 8'h02,
      LS_W    = 8'h04,
      LS_D    = 8'h08,
      LS_BU   = 8'h10,
      LS_HU   = 8'h20,
      LS_WU   = 8'h40,
      LS_NONE = 8'h80
   } ls_type_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   function automatic logic [3:0] size_of(input ls_type_e t);
      case (t)
         LS_B, LS_BU: return 4'd1;
         LS_H, LS_HU: return 4'd2;
         LS_W, LS_WU: return 4'd4;
         LS_D:        return 4'd8;
         default:     return 4'd0;
      endcase
   endfunction

   function automatic logic type_signed(input ls_type_e t);
      return (t == LS_B) || (t == LS_H) || (t == LS_W);
   endfunction

   // Doubleword and unsigned-word accesses only exist on a 64-bit datapath.
   function automatic ls_type_e decode_f3(input logic [2:0] f3, input logic xlen64);
      case (f3)
         F3_B:    return LS_B;
         F3_H:    return LS_H;
         F3_W:    return LS_W;
         F3_D:    return xlen64 ? LS_D : LS_NONE;
         F3_BU:   return LS_BU;
         F3_HU:   return LS_HU;
         F3_WU:   return xlen64 ? LS_WU : LS_NONE;
         default: return LS_NONE;
      endcase
   endfunction

endpackage

// File: rtl/lsu_seq_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave):
// req/gnt address phase, rvalid response phase, one beat outstanding.
interface lsu_seq_if #(parameter int XLEN = 32);

   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [XLEN-1:0]       mem_addr_o;
   logic [XLEN/8-1:0]     mem_be_o;
   logic [XLEN-1:0]       mem_wdata_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [XLEN-1:0]       mem_rdata_i;
   logic                  mem_err_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
   );

endinterface

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables and shifted write data per
// beat, and reassembly plus sign/zero extension of (possibly two-beat) load data.
module lsu_align
   import lsu_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int NB   = XLEN / 8,
   localparam int OW   = $clog2(NB)
) (
   input  ls_type_e          typ,
   input  logic [OW-1:0]     off,
   input  logic              beat,
   input  logic [XLEN-1:0]   wdata,
   output logic [NB-1:0]     be,
   output logic [XLEN-1:0]   wdata_sh,
   input  logic [XLEN-1:0]   rd0,
   input  logic [XLEN-1:0]   rd1,
   output logic [XLEN-1:0]   rdata
);

   logic [2*NB-1:0]          be_full;
   logic [2*XLEN-1:0]        wd_full;
   logic [XLEN-1:0]          rd_sh;
   logic signed [XLEN-1:0]   rd_sx;
   int                       ext_sh;

   always_comb begin
      // Lanes are laid out across a double word; the upper half belongs to beat 1.
      for (int i = 0; i < 2*NB; i++)
         be_full[i] = (i >= int'(off)) && (i < int'(off) + int'(size_of(typ)));
      wd_full  = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
      be       = beat ? be_full[2*NB-1:NB] : be_full[NB-1:0];
      wdata_sh = beat ? wd_full[2*XLEN-1:XLEN] : wd_full[XLEN-1:0];

      rd_sh  = XLEN'({rd1, rd0} >> {off, 3'b000});
      ext_sh = XLEN - 8*int'(size_of(typ));
      if (ext_sh < 0)
         ext_sh = 0;
      rd_sx = $signed(rd_sh << ext_sh);
      if (type_signed(typ))
         rdata = rd_sx >>> ext_sh;
      else
         rdata = (rd_sh << ext_sh) >> ext_sh;
   end

endmodule

// File: rtl/lsu_seq.sv
// Multi-cycle load/store sequencer: accepts one request, issues one or two aligned
// bus beats, assembles load data and returns a single response.
//
//   state | meaning
//   IDLE  | ready for a new request
//   ISSUE | mem_req_o held with stable addr/be/wdata until gnt
//   WAIT  | granted, waiting for the beat's rvalid
//   RESP  | one-cycle rsp_valid_o with data/err
module lsu_seq
   import lsu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit SPLIT_EN = 1'b1,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_funct3_i,
   input  logic              req_store_i,
   input  logic [XLEN-1:0]   req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic              rsp_valid_o,
   output logic [XLEN-1:0]   rsp_rdata_o,
   output logic              rsp_err_o,
   lsu_seq_if.master         mem
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] CNT_TC = WW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ISSUE = ISSUE;
   localparam logic [1:0] ST_WAIT  = WAIT;
   localparam logic [1:0] ST_RESP  = RESP;

   logic [1:0]        state;
   ls_type_e          typ_q;
   logic              store_q;
   logic [XLEN-1:0]   base_q;
   logic [OW-1:0]     off_q;
   logic [XLEN-1:0]   wdata_q;
   logic              beat_q;
   logic              split_q;
   logic              err_q;
   logic [XLEN-1:0]   rd0_q;
   logic [XLEN-1:0]   rd1_q;
   logic [WW-1:0]     cnt_q;

   ls_type_e          typ_d;
   logic [OW-1:0]     off_d;
   logic              cross_d;
   logic              timeout;
   logic              issuing;
   logic [NB-1:0]     al_be;
   logic [XLEN-1:0]   al_wdata;
   logic [XLEN-1:0]   al_rdata;

   assign typ_d   = decode_f3(req_funct3_i, XLEN == 64);
   assign off_d   = req_addr_i[OW-1:0];
   assign cross_d = (int'(off_d) + int'(size_of(typ_d))) > NB;
   assign timeout = (MAX_WAIT != 0) && (cnt_q == CNT_TC);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         typ_q   <= LS_NONE;
         store_q <= 1'b0;
         base_q  <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         beat_q  <= 1'b0;
         split_q <= 1'b0;
         err_q   <= 1'b0;
         rd0_q   <= '0;
         rd1_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  typ_q   <= typ_d;
                  store_q <= req_store_i;
                  base_q  <= {req_addr_i[XLEN-1:OW], {OW{1'b0}}};
                  off_q   <= off_d;
                  wdata_q <= req_wdata_i;
                  beat_q  <= 1'b0;
                  split_q <= cross_d;
                  rd0_q   <= '0;
                  rd1_q   <= '0;
                  cnt_q   <= '0;
                  // Rejected requests answer straight away without touching the bus.
                  if (typ_d == LS_NONE || (cross_d && !SPLIT_EN)) begin
                     err_q <= 1'b1;
                     state <= ST_RESP;
                  end else begin
                     err_q <= 1'b0;
                     state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (mem.mem_gnt_i) begin
                  cnt_q <= '0;
                  state <= ST_WAIT;
               end else if (timeout) begin
                  cnt_q <= '0;
                  err_q <= 1'b1;
                  state <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (mem.mem_rvalid_i) begin
                  cnt_q <= '0;
                  err_q <= err_q | mem.mem_err_i;
                  if (beat_q)
                     rd1_q <= mem.mem_rdata_i;
                  else
                     rd0_q <= mem.mem_rdata_i;
                  // Beat 1 is still issued after a beat-0 error so exactly one response results.
                  if (split_q && !beat_q) begin
                     beat_q <= 1'b1;
                     state  <= ST_ISSUE;
                  end else begin
                     state  <= ST_RESP;
                  end
               end else if (timeout) begin
                  cnt_q <= '0;
                  err_q <= 1'b1;
                  state <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .typ      (typ_q),
      .off      (off_q),
      .beat     (beat_q),
      .wdata    (wdata_q),
      .be       (al_be),
      .wdata_sh (al_wdata),
      .rd0      (rd0_q),
      .rd1      (rd1_q),
      .rdata    (al_rdata)
   );

   assign issuing         = (state == ST_ISSUE);
   assign mem.mem_req_o   = issuing;
   assign mem.mem_we_o    = issuing && store_q;
   assign mem.mem_addr_o  = !issuing ? '0 : (beat_q ? base_q + XLEN'(NB) : base_q);
   assign mem.mem_be_o    = issuing ? al_be : '0;
   assign mem.mem_wdata_o = issuing ? al_wdata : '0;

   assign req_ready_o = (state == ST_IDLE);
   assign rsp_valid_o = (state == ST_RESP);
   assign rsp_err_o   = (state == ST_RESP) && err_q;
   assign rsp_rdata_o = ((state == ST_RESP) && !err_q && !store_q) ? al_rdata : '0;

endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
- Parametrised, multi-cycle load/store unit. Successor to the combinational funct3 width decoder.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Generates the byte-enable mask and aligned write data, and drives a req/gnt/rvalid data-memory bus.
- Aligns and sign/zero-extends load data. Handles misaligned accesses by splitting them into two bus beats or by reporting an error.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64. At 64, ld/sd (funct3 011) and lwu (110) become legal.
- SPLIT_EN, 1, 1 = misaligned accesses split into two aligned beats; 0 = misaligned accesses return an error with no bus traffic.
- MAX_WAIT, 255, gnt/rvalid timeout in cycles before a bus error is forced; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit idle and able to accept a request
- req_funct3_i  in  3  RISC-V funct3
- req_store_i  in  1  1 = store, 0 = load
- req_addr_i  in  XLEN  byte address
- req_wdata_i  in  XLEN  store data, LSB-justified
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  XLEN  extended load data (0 for stores)
- rsp_err_o  out  1  illegal funct3, misaligned with SPLIT_EN=0, bus error, or timeout
- mem_req_o  out  1  bus request
- mem_we_o  out  1  write enable
- mem_addr_o  out  XLEN  word-aligned address (low log2(XLEN/8) bits zero)
- mem_be_o  out  XLEN/8  byte enables
- mem_wdata_o  out  XLEN  lane-shifted write data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  beat response valid (loads and stores)
- mem_rdata_i  in  XLEN  read data
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i

Behaviour:
- Reset: state=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_be_o=0; mem_wdata_o=0; wait counter=0.
- Reset mid-transaction abandons the transaction. Any late rvalid arriving in IDLE is ignored.
- Acceptance: a request is accepted when req_valid_i && req_ready_o. Fields are registered, and req_ready_o=0 until the cycle after rsp_valid_o.
- Decode: funct3 maps to a one-hot size/sign type (package). An illegal funct3 takes IDLE->RESP with err=1 and zero bus activity.
- Misalignment:
  - An access is misaligned if (addr mod size) != 0.
  - An access is split if offset+size > XLEN/8.
  - A misaligned access that stays within one word is not split; it is a single beat with shifted BE.
  - A word-crossing access with SPLIT_EN=0 -> RESP with err=1, no bus access.
- States:
  - IDLE -> ISSUE on accept.
  - ISSUE: mem_req_o=1 with addr/be/wdata held stable until mem_gnt_i; on gnt -> WAIT.
  - WAIT: on mem_rvalid_i, capture data. If beat 0 of a split access, go to ISSUE for beat 1 at addr+XLEN/8; otherwise go to RESP.
  - RESP: rsp_valid_o=1 for one cycle -> IDLE.
- Beat 0 lanes: BE = size mask << offset, truncated to the word; wdata = wdata << 8*offset.
- Beat 1 lanes: BE = remaining low lanes; wdata = wdata >> 8*(XLEN/8 - offset).
- Load assembly: beat data is concatenated {beat1, beat0} and shifted right by 8*offset. The result is then sign- or zero-extended per type. mem_rdata_i lanes with BE=0 are don't-care.
- Errors:
  - mem_err_i on either beat sets a sticky err. A split access still issues beat 1 after a beat-0 error, so the core always sees exactly one response.
  - rsp_rdata_o=0 whenever err=1.
- Timeout: the wait counter increments in ISSUE/WAIT and clears on each gnt/rvalid. On reaching MAX_WAIT -> RESP with err=1, and mem_req_o drops.
- Bus timing: mem_gnt_i and mem_rvalid_i in the same cycle as a request is legal only via the WAIT state. rvalid is never expected before gnt, and gnt-cycle rvalid is ignored. One outstanding beat at a time.
- Latency: aligned access with gnt and rvalid in the first cycle each gives accept -> rsp_valid_o after 3 cycles. A split access adds 2 cycles.

Decomposition:
- Package lsu_pkg:
  - ls_type_e: one-hot B, H, W, D, BU, HU, WU, NONE.
  - lsu_state_e: IDLE, ISSUE, WAIT, RESP.
  - funct3 constants.
  - Function size_of(type).
- Sub-module lsu_align (combinational):
  - Store side: type, offset, beat -> be, shifted wdata.
  - Load side: beats, offset, type -> extended rdata.
- lsu_seq holds the FSM, capture registers, timeout counter and error flag.

Test Plan:
- Aligned lw at 0x100; mem returns 0x8899AABB -> mem_be_o=1111, mem_addr_o=0x100, rsp_rdata_o=0x8899AABB, err=0, rsp_valid_o 3 cycles after accept.
- lb at 0x103, word 0x80FFFFFF -> be=1000, rdata=0xFFFFFF80. lbu at the same address -> 0x00000080.
- sh at 0x102, wdata=0x1234 -> single beat: be=1100, mem_wdata_o=0x12340000, mem_we_o=1.
- SPLIT_EN=1, lw at 0x203; word@0x200=0x44xxxxxx, word@0x204=0xxx332211 -> beats at be=1000 then be=0111, rdata=0x33221144. With SPLIT_EN=0 -> err=1, mem_req_o never asserted.
- Illegal funct3 (011 at XLEN=32) -> rsp_valid_o with err=1 and no bus request. Separately, mem_gnt_i held low for MAX_WAIT cycles -> err=1 and mem_req_o drops.
- Reset asserted in WAIT with a late rvalid 2 cycles after reset -> all outputs at reset values, no rsp_valid_o, req_ready_o=1.
